inv_round_stage: RTL and testbench

//   Pipelined decryption-side AES round back end. Computes InvShiftRows, then AddRoundKey,

---
 rtl/inv_round_stage.sv | 104 ++++++++++
 tb/tb_inv_round_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_round_stage.sv
// Decryption round back end: InvShiftRows, AddRoundKey, then InvMixColumns
// (skipped on the final round), in two valid/ready register stages.
module inv_round_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] in_state,
    input  logic [0:127] in_key,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] out_state,
    output logic         out_valid,
    input  logic         out_ready
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:31] imc_col(input logic [0:31] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*i +: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    logic [0:127] sr;
    logic [0:127] x;
    logic [0:127] x1;
    logic [0:127] y;
    logic         last1;
    logic         v1;
    logic         v2;
    logic         adv1;
    logic         adv2;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Row r of the output takes column (c - r) mod 4 of the input.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(4*c+r) +: 8] = in_state[8*(4*((c+4-r)%4)+r) +: 8];
            end
        end
    end

    assign x = sr ^ in_key;

    always_comb begin
        y = '0;
        for (int c = 0; c < 4; c++) begin
            y[32*c +: 32] = last1 ? x1[32*c +: 32]
                                  : imc_col(x1[32*c +: 32]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            x1    <= '0;
            last1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                x1    <= x;
                last1 <= in_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            out_state <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_state <= y;
            end
        end
    end

endmodule

// File: tb/tb_inv_round_stage.sv
// Directed-vector and stream bench for inv_round_stage against a
// byte-level reference model with a scoreboard queue.
module tb_inv_round_stage;

    logic         clk;
    logic         rst;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_state;
    logic         out_valid;
    logic         out_ready;

    int pass_cnt = 0;
    int total_cnt = 0;

    inv_round_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_state (out_state),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s,
                                               input logic [127:0] key,
                                               input logic l);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] o [16];
        logic [7:0] base [4];
        logic [127:0] res;
        base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*((c+r)%4)+r] = b[4*c+r];
        for (int i = 0; i < 16; i++) t[i] = t[i] ^ key[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                o[4*c+r] = 8'h00;
                for (int j = 0; j < 4; j++)
                    o[4*c+r] = o[4*c+r] ^ gm(t[4*c+j], base[(j-r+4)%4]);
            end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = l ? t[i] : o[i];
        return res;
    endfunction

    // Scoreboard: push on accept, pop on emit, check hold while stalled.
    logic [127:0] q [$];
    logic         pstall;
    logic [127:0] pstate;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            pstall <= 1'b0;
        end else begin
            if (pstall) begin
                chk("hold_valid", {127'd0, out_valid}, 128'd1);
                chk("hold_data", out_state, pstate);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", {127'd0, out_valid}, 128'd0);
                else chk("stream_data", out_state, q.pop_front());
            end
            if (in_valid && in_ready)
                q.push_back(ref_round(in_state, in_key, in_last));
            pstall <= out_valid && !out_ready;
            pstate <= out_state;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic v);
        in_valid = v;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_last  = 1'($urandom_range(0, 1));
    endtask

    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input int i);
        tick();
        in_state  = vecs[i].st;
        in_key    = vecs[i].key;
        in_last   = vecs[i].last;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk($sformatf("v%0d_ready", i), {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        in_state = '0;
        in_key   = '0;
        chk($sformatf("v%0d_early", i), {127'd0, out_valid}, 128'd0);
        tick();
        chk($sformatf("v%0d_valid", i), {127'd0, out_valid}, 128'd1);
        chk($sformatf("v%0d_data", i), out_state, vecs[i].exp);
        tick();
        chk($sformatf("v%0d_bubble", i), {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        int run;
        int maxrun;
        int seen;
        logic [127:0] held;

        vecs[0] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1,
                    128'h000d0a07_04010e0b_0805020f_0c090603};
        vecs[1] = '{{4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'hdb135345}}};
        vecs[2] = '{128'h0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff};
        vecs[3] = '{128'h0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0,
                    ref_round(128'h0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0)};
        vecs[4] = '{128'h0, 128'h9fdc589d_d5d5d7d6_4d7ebdf8_8e4da1bc, 1'b0,
                    128'hf20a225c_d4d4d4d5_2d26314c_db135345};
        vecs[5] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, {128{1'b1}}, 1'b1,
                    128'hfff2f5f8_fbfef1f4_f7fafdf0_f3f6f9fc};
        vecs[6] = '{{4{32'hc6c6c6c6}}, 128'h0, 1'b0, {4{32'hc6c6c6c6}}};

        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        in_key = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_state", out_state, 128'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", {127'd0, in_ready}, 128'd1);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Eight states back to back with no backpressure.
        run = 0;
        maxrun = 0;
        seen = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive_rand(cyc < 8);
            tick();
            if (out_valid) begin
                run++;
                seen++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        in_valid = 1'b0;
        chk("b2b_run", 128'(maxrun), 128'd8);
        chk("b2b_count", 128'(seen), 128'd8);

        // Downstream stall: both stages fill, then in_ready drops.
        tick();
        out_ready = 1'b0;
        drive_rand(1'b1);
        chk("stall_rdy_a", {127'd0, in_ready}, 128'd1);
        tick();
        drive_rand(1'b1);
        chk("stall_rdy_b", {127'd0, in_ready}, 128'd1);
        tick();
        drive_rand(1'b1);
        chk("stall_full", {127'd0, in_ready}, 128'd0);
        chk("stall_ov", {127'd0, out_valid}, 128'd1);
        held = out_state;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rdy_low", {127'd0, in_ready}, 128'd0);
            chk("stall_hold", out_state, held);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            drive_rand(1'b1);
        end
        in_valid = 1'b0;

        // Random valid/ready soak against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            tick();
            drive_rand(1'($urandom_range(0, 3) != 0));
            out_ready = 1'($urandom_range(0, 2) != 0);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("drain_empty", 128'(q.size()), 128'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        drive_rand(1'b1);
        tick();
        drive_rand(1'b1);
        tick();
        in_valid = 1'b0;
        chk("prerst_ov", {127'd0, out_valid}, 128'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_state", out_state, 128'd0);
        chk("arst_ready", {127'd0, in_ready}, 128'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_ov", {127'd0, out_valid}, 128'd0);
        run_vec(0);
        for (int i = 0; i < 4; i++) tick();
        chk("final_empty", 128'(q.size()), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
